serial_subtractor_32: RTL and testbench



---
 rtl/sub_pkg.sv | 13 +
 rtl/sub_chunk.sv | 19 +
 rtl/serial_subtractor_32.sv | 136 +++++++++++++
 tb/tb_serial_subtractor_32.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/sub_pkg.sv
// Shared types and sizing helpers for the chunked serial subtractor.
package sub_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam int DEF_WIDTH   = 32;
    localparam int DEF_CHUNK_W = 8;

    function automatic int chunk_count(input int width, input int chunk_w);
        return width / chunk_w;
    endfunction

endpackage

// File: rtl/sub_chunk.sv
// Combinational CHUNK_W-bit subtract-with-borrow stage, reused every RUN cycle.
module sub_chunk #(
    parameter int CHUNK_W = 8
) (
    input  logic [CHUNK_W-1:0] a_chunk,
    input  logic [CHUNK_W-1:0] b_chunk,
    input  logic               bin,
    output logic [CHUNK_W-1:0] diff_chunk,
    output logic               bout
);

    logic [CHUNK_W:0] full;

    // The extra top bit goes to 1 exactly when the chunk subtraction underflows.
    assign full       = {1'b0, a_chunk} - {1'b0, b_chunk} - {{CHUNK_W{1'b0}}, bin};
    assign diff_chunk = full[CHUNK_W-1:0];
    assign bout       = full[CHUNK_W];

endmodule

// File: rtl/serial_subtractor_32.sv
// Multi-cycle diff = a - b - b_in, CHUNK_W bits per clock, LSB chunk first.
// Define SUB_OVERFLOW_EN to build the signed-overflow flag; otherwise ovf is tied low.
module serial_subtractor_32
    import sub_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int CHUNK_W = DEF_CHUNK_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             b_in,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             b_out,
    output logic             ovf
);

    localparam int N     = chunk_count(WIDTH, CHUNK_W);
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    generate
        if (WIDTH % CHUNK_W != 0) begin : g_bad_chunk
            $error("CHUNK_W must divide WIDTH exactly");
        end
    endgenerate

    state_t             state_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic [WIDTH-1:0]   a_reg;
    logic [WIDTH-1:0]   b_reg;
    logic [WIDTH-1:0]   diff_reg;
    logic               borrow_reg;
    logic               ready_reg;
    logic               done_reg;
    logic               b_out_reg;

    logic [CHUNK_W-1:0] a_chunks [N];
    logic [CHUNK_W-1:0] b_chunks [N];
    logic [CHUNK_W-1:0] diff_chunk;
    logic               chunk_bout;
    logic               last_chunk;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_slice
            assign a_chunks[gi] = a_reg[gi*CHUNK_W +: CHUNK_W];
            assign b_chunks[gi] = b_reg[gi*CHUNK_W +: CHUNK_W];
        end
    endgenerate

    assign last_chunk = (cnt_reg == CNT_W'(N - 1));

    sub_chunk #(.CHUNK_W(CHUNK_W)) u_chunk (
        .a_chunk    (a_chunks[cnt_reg]),
        .b_chunk    (b_chunks[cnt_reg]),
        .bin        (borrow_reg),
        .diff_chunk (diff_chunk),
        .bout       (chunk_bout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            a_reg      <= '0;
            b_reg      <= '0;
            diff_reg   <= '0;
            borrow_reg <= 1'b0;
            ready_reg  <= 1'b1;
            done_reg   <= 1'b0;
            b_out_reg  <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        a_reg      <= a;
                        b_reg      <= b;
                        borrow_reg <= b_in;
                        cnt_reg    <= '0;
                        ready_reg  <= 1'b0;
                        state_reg  <= RUN;
                    end
                end
                RUN: begin
                    diff_reg[cnt_reg*CHUNK_W +: CHUNK_W] <= diff_chunk;
                    borrow_reg <= chunk_bout;
                    cnt_reg    <= cnt_reg + 1'b1;
                    if (last_chunk) begin
                        b_out_reg <= chunk_bout;
                        done_reg  <= 1'b1;
                        state_reg <= DONE;
                    end
                end
                DONE: begin
                    ready_reg <= 1'b1;
                    state_reg <= IDLE;
                end
                default: begin
                    ready_reg <= 1'b1;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

`ifdef SUB_OVERFLOW_EN
    logic ovf_reg;

    // The final diff MSB is the top bit of the last chunk being written this edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_reg <= 1'b0;
        end else if (state_reg == IDLE && start) begin
            ovf_reg <= 1'b0;
        end else if (state_reg == RUN && last_chunk) begin
            ovf_reg <= (a_reg[WIDTH-1] != b_reg[WIDTH-1]) &&
                       (diff_chunk[CHUNK_W-1] != a_reg[WIDTH-1]);
        end
    end

    assign ovf = ovf_reg;
`else
    assign ovf = 1'b0;
`endif

    assign ready = ready_reg;
    assign done  = done_reg;
    assign diff  = diff_reg;
    assign b_out = b_out_reg;

endmodule

// File: tb/tb_serial_subtractor_32.sv
// Directed and small random checks of serial_subtractor_32 (ovf expectations follow SUB_OVERFLOW_EN).
module tb_serial_subtractor_32;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        b_in;
    logic        ready;
    logic        done;
    logic [31:0] diff;
    logic        b_out;
    logic        ovf;

    int checks   = 0;
    int failures = 0;

`ifdef SUB_OVERFLOW_EN
    localparam bit OVF_ON = 1'b1;
`else
    localparam bit OVF_ON = 1'b0;
`endif

    serial_subtractor_32 dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .b_in  (b_in),
        .ready (ready),
        .done  (done),
        .diff  (diff),
        .b_out (b_out),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Runs one operation from IDLE, starting at a negedge; checks latency and results.
    task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_v, input logic tbin,
                          input logic [31:0] exp_diff, input logic exp_bout,
                          input logic exp_ovf, input string tag);
        int cycles;
        a = ta; b = tb_v; b_in = tbin; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = 32'hDEAD_BEEF; b = 32'h1234_5678; b_in = ~tbin;
        check({tag, ".ready_low"}, 64'(ready), 64'd0);
        cycles = 1;
        while (!done && cycles < 20) begin
            @(negedge clk);
            cycles++;
        end
        check({tag, ".latency"}, 64'(cycles), 64'd5);
        check({tag, ".diff"}, 64'(diff), 64'(exp_diff));
        check({tag, ".b_out"}, 64'(b_out), 64'(exp_bout));
        check({tag, ".ovf"}, 64'(ovf), 64'(exp_ovf & OVF_ON));
        @(negedge clk);
        check({tag, ".done_pulse"}, 64'(done), 64'd0);
        check({tag, ".ready_back"}, 64'(ready), 64'd1);
        $display("op %s a=%08h b=%08h bin=%0d diff=%08h b_out=%0d ovf=%0d", tag, ta, tb_v, tbin, diff, b_out, ovf);
    endtask

    initial begin
        logic [32:0] ref33;
        logic [31:0] ra, rb, ldiff;
        logic        rbin, rovf;
        int          pulses;

        rst = 1'b1; start = 1'b0; a = '0; b = '0; b_in = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("reset.ready", 64'(ready), 64'd1);
        check("reset.done",  64'(done),  64'd0);
        check("reset.diff",  64'(diff),  64'd0);
        check("reset.b_out", 64'(b_out), 64'd0);
        check("reset.ovf",   64'(ovf),   64'd0);

        // rst and start together: reset must win.
        start = 1'b1; a = 32'd9; b = 32'd1;
        @(negedge clk);
        check("rst_start.ready", 64'(ready), 64'd1);
        start = 1'b0; rst = 1'b0;
        @(negedge clk);
        check("rst_start.idle", 64'(ready), 64'd1);

        run_op(32'd5, 32'd3, 1'b0, 32'd2, 1'b0, 1'b0, "basic");
        run_op(32'd0, 32'd1, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0, "wrap");
        run_op(32'h0000_0100, 32'h0000_00FF, 1'b1, 32'd0, 1'b0, 1'b0, "chunk_borrow");
        run_op(32'h8000_0000, 32'd1, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1, "neg_ovf");
        run_op(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h8000_0000, 1'b1, 1'b1, "pos_ovf");
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, "all_ones_bin");
        run_op(32'h1234_5678, 32'h0000_0678, 1'b0, 32'h1234_5000, 1'b0, 1'b0, "mixed");

        // start held high through RUN while operands change: exactly one result.
        a = 32'd10; b = 32'd3; b_in = 1'b0; start = 1'b1;
        @(negedge clk);
        pulses = 0; ldiff = '0;
        for (int i = 0; i < 5; i++) begin
            a = $urandom; b = $urandom; b_in = 1'(i);
            @(negedge clk);
            if (done) begin
                pulses++;
                ldiff = diff;
            end
        end
        check("hold.pulses", 64'(pulses), 64'd1);
        check("hold.diff", 64'(ldiff), 64'd7);
        check("hold.ready_idle", 64'(ready), 64'd1);
        start = 1'b0;
        @(negedge clk);
        check("hold.no_requeue", 64'(ready), 64'd1);
        $display("op hold pulses=%0d diff=%08h", pulses, ldiff);

        // Reset during the 2nd RUN cycle discards the operation.
        a = 32'h0000_00FF; b = 32'd1; b_in = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst.ready", 64'(ready), 64'd1);
        check("midrst.diff",  64'(diff),  64'd0);
        check("midrst.b_out", 64'(b_out), 64'd0);
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            if (done) pulses++;
            @(negedge clk);
        end
        check("midrst.no_done", 64'(pulses), 64'd0);
        $display("op midrst pulses=%0d", pulses);
        run_op(32'd10, 32'd4, 1'b0, 32'd6, 1'b0, 1'b0, "after_rst");

        // Random regression against 33-bit reference arithmetic.
        for (int i = 0; i < 200; i++) begin
            ra = $urandom; rb = $urandom; rbin = 1'($urandom_range(1, 0));
            if (i % 8 == 0) rb = ra;
            ref33 = {1'b0, ra} - {1'b0, rb} - {32'd0, rbin};
            rovf  = (ra[31] != rb[31]) && (ref33[31] != ra[31]);
            run_op(ra, rb, rbin, ref33[31:0], ref33[32], rovf, $sformatf("rand%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
